// File: rtl/pblaze_irq_timer_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pblaze_irq_timer_port_if                                             |
// | KCPSM3 port bus: port_id/strobe I/O plus interrupt/ack handshake.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pblaze_irq_timer_port_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface
`default_nettype wire

// File: rtl/pblaze_irq_timer_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pblaze_irq_timer_port                                                |
// | Reload timer + synchronised external event, interrupt source on the  |
// | KCPSM3 port bus. Option: PBLAZE_IRQ_AUTO_CLEAR_EN (ack clears pend). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pblaze_irq_timer_port #(
    parameter logic [7:0]  BASE_ADDR   = 8'h10,
    parameter int unsigned CLK_FREQ_HZ = 25000000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pblaze_irq_timer_port_if.slave bus,
    input  wire logic              ext_event_i
);

    localparam logic [31:0] c_RST_FULL   = 32'(CLK_FREQ_HZ - 1);
    localparam logic [23:0] c_RELOAD_RST = c_RST_FULL[23:0];

    localparam logic [2:0] c_OFF_CTRL   = 3'd0;
    localparam logic [2:0] c_OFF_STATUS = 3'd1;
    localparam logic [2:0] c_OFF_RL0    = 3'd2;
    localparam logic [2:0] c_OFF_RL1    = 3'd3;
    localparam logic [2:0] c_OFF_RL2    = 3'd4;
    localparam logic [2:0] c_OFF_MISSED = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t      state_q;
    logic        irq_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  pend_q,   pend_d;
    logic [7:0]  missed_q, missed_d;
    logic [23:0] reload_q, reload_d;
    logic [23:0] count_q,  count_d;
    logic [7:0]  in_port_q, in_port_d;
    logic        sync1_q, sync2_q, ext_prev_q;

    logic        w_match;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_wr_reload;
    logic        w_rd_missed;
    logic        w_tick;
    logic        w_ext_set;
    logic        w_miss;
    logic [1:0]  w_w1c;
    logic [1:0]  w_autoclr;

    assign w_match     = (bus.port_id[7:3] == BASE_ADDR[7:3]);
    assign w_off       = bus.port_id[2:0];
    assign w_wr        = bus.write_strobe & w_match;
    assign w_wr_reload = w_wr & ((w_off == c_OFF_RL0) | (w_off == c_OFF_RL1) |
                                 (w_off == c_OFF_RL2));
    assign w_rd_missed = bus.read_strobe & w_match & (w_off == c_OFF_MISSED);
    assign w_tick      = ctrl_q[0] & (count_q == 24'd0);
    assign w_ext_set   = sync2_q & ~ext_prev_q & ctrl_q[1];
    assign w_miss      = w_tick & pend_q[0];
    assign w_w1c       = (w_wr && (w_off == c_OFF_STATUS)) ? bus.out_port[1:0] : 2'b00;

`ifdef PBLAZE_IRQ_AUTO_CLEAR_EN
    // Ack retires the highest-priority source only; timer wins over external.
    always_comb begin
        w_autoclr = 2'b00;
        if (state_q == S_ASSERT && ctrl_q[2] && bus.interrupt_ack) begin
            w_autoclr = pend_q[0] ? 2'b01 : 2'b10;
        end
    end
`else
    assign w_autoclr = 2'b00;
`endif

    always_comb begin
        reload_d = reload_q;
        if (w_wr && w_off == c_OFF_RL0) reload_d[7:0]   = bus.out_port;
        if (w_wr && w_off == c_OFF_RL1) reload_d[15:8]  = bus.out_port;
        if (w_wr && w_off == c_OFF_RL2) reload_d[23:16] = bus.out_port;
    end

    // A disabled timer parks at RELOAD so re-enabling always starts a full period.
    always_comb begin
        if (w_wr_reload) begin
            count_d = reload_d;
        end else if (!ctrl_q[0] || w_tick) begin
            count_d = reload_q;
        end else begin
            count_d = count_q - 24'd1;
        end
    end

    always_comb begin
        pend_d = (pend_q & ~w_w1c & ~w_autoclr) | {w_ext_set, w_tick};
    end

    // A miss landing on the clearing read is kept rather than lost.
    always_comb begin
        missed_d = missed_q;
        if (w_rd_missed) begin
            missed_d = w_miss ? 8'd1 : 8'd0;
        end else if (w_miss && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end
    end

    always_comb begin
        in_port_d = 8'h00;
        if (w_match) begin
            case (w_off)
                c_OFF_CTRL:   in_port_d = {5'b0, ctrl_q};
                c_OFF_STATUS: in_port_d = {6'b0, pend_q};
                c_OFF_RL0:    in_port_d = reload_q[7:0];
                c_OFF_RL1:    in_port_d = reload_q[15:8];
                c_OFF_RL2:    in_port_d = reload_q[23:16];
                c_OFF_MISSED: in_port_d = missed_q;
                default:      in_port_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= 3'b000;
            pend_q     <= 2'b00;
            missed_q   <= 8'h00;
            reload_q   <= c_RELOAD_RST;
            count_q    <= c_RELOAD_RST;
            in_port_q  <= 8'h00;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            if (w_wr && w_off == c_OFF_CTRL) ctrl_q <= bus.out_port[2:0];
            pend_q     <= pend_d;
            missed_q   <= missed_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            in_port_q  <= in_port_d;
            sync1_q    <= ext_event_i;
            sync2_q    <= sync1_q;
            ext_prev_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[2] && pend_q != 2'b00) begin
                        state_q <= S_ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (!ctrl_q[2]) begin
                        state_q <= S_IDLE;
                        irq_q   <= 1'b0;
                    end else if (bus.interrupt_ack) begin
                        state_q <= S_HOLDOFF;
                        irq_q   <= 1'b0;
                    end
                end
                S_HOLDOFF: begin
                    irq_q <= 1'b0;
`ifdef PBLAZE_IRQ_AUTO_CLEAR_EN
                    state_q <= S_IDLE;
`else
                    if (!ctrl_q[2] || pend_q == 2'b00) state_q <= S_IDLE;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_port   = in_port_q;
    assign bus.interrupt = irq_q;

endmodule
`default_nettype wire
